// File: rtl/iwrite_controller.sv
// Producer side of the activation ping-pong BRAMs: spreads an input word stream
// round-robin over the banks and publishes per-bank {half, count} write pointers.
module iwrite_controller #(
  parameter int NUM_BANKS   = 4,
  parameter int WRITE_WIDTH = 64,
  parameter int WRITE_DEPTH = 512,
  parameter int PARAM_WIDTH = 32
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [PARAM_WIDTH-1:0]                         param_data,
  input  logic                                           param_valid,
  output logic                                           param_ready,
  input  logic [WRITE_WIDTH-1:0]                         act_in_data,
  input  logic                                           act_in_valid,
  output logic                                           act_in_ready,
  output logic [NUM_BANKS-1:0]                           enaA,
  output logic [NUM_BANKS-1:0]                           weA,
  output logic [$clog2(WRITE_DEPTH):0]                   addrA,
  output logic [WRITE_WIDTH-1:0]                         diA,
  output logic [NUM_BANKS-1:0][$clog2(WRITE_DEPTH):0]    write_addr_pingpong_data,
  input  logic                                           rd_release_valid,
  input  logic                                           rd_release_data,
  output logic                                           rd_release_ready,
  output logic                                           fill_done
);

  localparam int AW = $clog2(WRITE_DEPTH * NUM_BANKS);
  localparam int DW = $clog2(WRITE_DEPTH);
  localparam int CW = AW + 3;
  localparam int FW = 8;
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {IDLE, PARAM_READ, WRITE, WAIT_BUF} state_t;

  state_t                        r_state, w_next_state;
  logic [CW-1:0]                 r_words_per_fill, r_word_cnt;
  logic [FW-1:0]                 r_num_fills, r_fill_cnt;
  logic [BW-1:0]                 r_bank_idx, w_bank_idx_next;
  logic [NUM_BANKS-1:0][DW-1:0]  r_bank_addr;
  logic                          r_pp;
  logic [1:0]                    r_buf_full, w_buf_full_next;
  logic                          r_rel_ready, r_fill_done;
  logic [NUM_BANKS-1:0]          r_ena, w_bank_onehot;
  logic [DW:0]                   r_addr;
  logic [WRITE_WIDTH-1:0]        r_di;
  logic                          r_wr_en, r_wr_last;
  logic [BW-1:0]                 r_wr_bank;
  logic                          r_inc_en, r_inc_last, r_inc_pp;
  logic [BW-1:0]                 r_inc_bank;
  logic [NUM_BANKS-1:0][DW:0]    r_ptr;
  logic                          w_accept, w_fill_end, w_last_fill, w_param_hs, w_release;
  logic                          w_unused_param;

  assign w_unused_param  = ^param_data[PARAM_WIDTH-1:AW+11];

  assign param_ready     = (r_state == PARAM_READ);
  assign act_in_ready    = (r_state == WRITE) && !r_buf_full[r_pp];
  assign rd_release_ready = r_rel_ready;
  assign fill_done       = r_fill_done;
  assign enaA            = r_ena;
  assign weA             = r_ena;
  assign addrA           = r_addr;
  assign diA             = r_di;
  assign write_addr_pingpong_data = r_ptr;

  assign w_param_hs      = param_valid && param_ready;
  assign w_accept        = act_in_valid && act_in_ready;
  assign w_release       = rd_release_valid && r_rel_ready;
  assign w_fill_end      = w_accept && (r_word_cnt == r_words_per_fill - CW'(1));
  assign w_last_fill     = w_fill_end && (r_fill_cnt == r_num_fills - FW'(1));
  assign w_bank_onehot   = NUM_BANKS'(1) << r_bank_idx;
  assign w_bank_idx_next = (r_bank_idx == BW'(NUM_BANKS - 1)) ? '0 : r_bank_idx + BW'(1);

  // A fill completing on a half wins over a release of that same half.
  always_comb begin
    w_buf_full_next = r_buf_full;
    if (w_release)  w_buf_full_next[rd_release_data] = 1'b0;
    if (w_fill_end) w_buf_full_next[r_pp] = 1'b1;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:       w_next_state = PARAM_READ;
      PARAM_READ: if (w_param_hs) w_next_state = WRITE;
      WRITE: begin
        if (w_last_fill)           w_next_state = IDLE;
        else if (r_buf_full[r_pp]) w_next_state = WAIT_BUF;
      end
      WAIT_BUF:   if (!r_buf_full[r_pp]) w_next_state = WRITE;
      default:    w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rel_ready      <= 1'b0;
      r_buf_full       <= 2'b00;
      r_fill_done      <= 1'b0;
      r_wr_en          <= 1'b0;
      r_ena            <= '0;
      r_words_per_fill <= '0;
      r_num_fills      <= '0;
      r_word_cnt       <= '0;
      r_bank_idx       <= '0;
      r_fill_cnt       <= '0;
      r_bank_addr      <= '0;
      r_pp             <= 1'b0;
      r_wr_bank        <= '0;
      r_wr_last        <= 1'b0;
      r_addr           <= '0;
      r_di             <= '0;
    end else begin
      r_rel_ready <= 1'b1;
      r_buf_full  <= w_buf_full_next;
      r_fill_done <= w_last_fill;
      r_wr_en     <= w_accept;
      r_ena       <= w_accept ? w_bank_onehot : '0;
      if (w_param_hs) begin
        r_words_per_fill <= param_data[AW+2:0];
        r_num_fills      <= param_data[AW+10:AW+3];
        r_word_cnt       <= '0;
        r_bank_idx       <= '0;
        r_fill_cnt       <= '0;
        r_bank_addr      <= '0;
      end else if (w_accept) begin
        r_wr_bank <= r_bank_idx;
        r_wr_last <= w_fill_end;
        r_addr    <= {r_bank_addr[r_bank_idx], r_pp};
        r_di      <= act_in_data;
        if (w_fill_end) begin
          r_word_cnt  <= '0;
          r_bank_idx  <= '0;
          r_bank_addr <= '0;
          r_pp        <= ~r_pp;
          r_fill_cnt  <= r_fill_cnt + FW'(1);
        end else begin
          r_word_cnt               <= r_word_cnt + CW'(1);
          r_bank_idx               <= w_bank_idx_next;
          r_bank_addr[r_bank_idx]  <= r_bank_addr[r_bank_idx] + DW'(1);
        end
      end
    end
  end

  // Pointers trail the BRAM write by one more stage so the reader never sees
  // a count for a word that has not yet landed in the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc_en   <= 1'b0;
      r_inc_last <= 1'b0;
      r_inc_pp   <= 1'b0;
      r_inc_bank <= '0;
      r_ptr      <= '0;
    end else begin
      r_inc_en   <= r_wr_en;
      r_inc_last <= r_wr_last;
      r_inc_bank <= r_wr_bank;
      r_inc_pp   <= r_pp;
      if (r_inc_en) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (r_inc_last)
            r_ptr[b] <= {r_inc_pp, {DW{1'b0}}};
          else if (BW'(b) == r_inc_bank)
            r_ptr[b][DW-1:0] <= r_ptr[b][DW-1:0] + DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_iwrite_controller.sv
// Directed bench for iwrite_controller: a negedge monitor keeps a scoreboard of
// expected BRAM writes and a delayed pointer model, the main block drives scenarios.
module tb_iwrite_controller;

  localparam int NB = 4;
  localparam int WW = 64;
  localparam int DW = 9;

  logic                   clk;
  logic                   rst_n;
  logic [31:0]            param_data;
  logic                   param_valid;
  logic                   param_ready;
  logic [WW-1:0]          act_in_data;
  logic                   act_in_valid;
  logic                   act_in_ready;
  logic [NB-1:0]          enaA;
  logic [NB-1:0]          weA;
  logic [DW:0]            addrA;
  logic [WW-1:0]          diA;
  logic [NB-1:0][DW:0]    ptrs;
  logic                   rd_release_valid;
  logic                   rd_release_data;
  logic                   rd_release_ready;
  logic                   fill_done;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {int bank; int addr; logic [WW-1:0] data;} wr_t;
  typedef struct {bit valid; int bank; bit last; bit newpp;} ev_t;

  wr_t        expQ[$];
  wr_t        curW;
  ev_t        dl[3];
  int         mWpf;
  int         mBank;
  int         mWordCnt;
  int         mAddr[NB];
  bit         mPp;
  logic [DW:0] expPtr[NB];

  iwrite_controller dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .param_data               (param_data),
    .param_valid              (param_valid),
    .param_ready              (param_ready),
    .act_in_data              (act_in_data),
    .act_in_valid             (act_in_valid),
    .act_in_ready             (act_in_ready),
    .enaA                     (enaA),
    .weA                      (weA),
    .addrA                    (addrA),
    .diA                      (diA),
    .write_addr_pingpong_data (ptrs),
    .rd_release_valid         (rd_release_valid),
    .rd_release_data          (rd_release_data),
    .rd_release_ready         (rd_release_ready),
    .fill_done                (fill_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no end of test, required finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyParams(input int wpf, input int nf);
    int waited;
    waited = 0;
    mWpf = wpf;
    param_data = (32'(nf) << 14) | 32'(wpf);
    param_valid = 1'b1;
    @(negedge clk);
    while (!param_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("param_handshake", 64'(param_ready), 64'd1);
    @(posedge clk);
    #1;
    param_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [WW-1:0] data);
    int waited;
    waited = 0;
    act_in_data  = data;
    act_in_valid = 1'b1;
    @(negedge clk);
    while (!act_in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("beat_handshake", 64'(act_in_ready), 64'd1);
    @(posedge clk);
    #1;
    act_in_valid = 1'b0;
  endtask

  task automatic doRelease(input logic half);
    rd_release_valid = 1'b1;
    rd_release_data  = half;
    @(negedge clk);
    checkOutput("release_ready", 64'(rd_release_ready), 64'd1);
    @(posedge clk);
    #1;
    rd_release_valid = 1'b0;
  endtask

  task automatic doReset();
    act_in_valid     = 1'b0;
    param_valid      = 1'b0;
    rd_release_valid = 1'b0;
    rst_n            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
  endtask

  // Scoreboard and pointer model; a beat seen at negedge n is written during
  // the cycle after the next posedge and its pointer is visible at negedge n+3.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      for (int i = 0; i < 3; i++) dl[i].valid = 1'b0;
      mBank    = 0;
      mWordCnt = 0;
      mPp      = 1'b0;
      for (int b = 0; b < NB; b++) begin
        mAddr[b]  = 0;
        expPtr[b] = '0;
      end
    end else begin
      if (expQ.size() > 0) begin
        curW = expQ.pop_front();
        checkOutput("wr_enaA", 64'(enaA), 64'(1) << curW.bank);
        checkOutput("wr_weA", 64'(weA), 64'(1) << curW.bank);
        checkOutput("wr_addrA", 64'(addrA), 64'(curW.addr));
        checkOutput("wr_diA", diA, curW.data);
      end else begin
        checkOutput("no_write", 64'({enaA, weA}), 64'd0);
      end
      if (dl[2].valid) begin
        if (dl[2].last) begin
          for (int b = 0; b < NB; b++) expPtr[b] = {dl[2].newpp, 9'd0};
        end else begin
          expPtr[dl[2].bank] = expPtr[dl[2].bank] + 1'b1;
        end
      end
      dl[2] = dl[1];
      dl[1] = dl[0];
      dl[0].valid = 1'b0;
      for (int b = 0; b < NB; b++)
        checkOutput($sformatf("ptr_bank%0d", b), 64'(ptrs[b]), 64'(expPtr[b]));
      if (act_in_valid && act_in_ready) begin
        curW.bank = mBank;
        curW.addr = mAddr[mBank] * 2 + int'(mPp);
        curW.data = act_in_data;
        expQ.push_back(curW);
        dl[0].valid = 1'b1;
        dl[0].bank  = mBank;
        dl[0].last  = (mWordCnt == mWpf - 1);
        if (dl[0].last) begin
          mWordCnt = 0;
          mBank    = 0;
          for (int b = 0; b < NB; b++) mAddr[b] = 0;
          mPp = ~mPp;
        end else begin
          mWordCnt++;
          mAddr[mBank]++;
          mBank = (mBank + 1) % NB;
        end
        dl[0].newpp = mPp;
      end
    end
  end

  initial begin
    rst_n            = 1'b0;
    param_data       = '0;
    param_valid      = 1'b0;
    act_in_data      = '0;
    act_in_valid     = 1'b0;
    rd_release_valid = 1'b0;
    rd_release_data  = 1'b0;
    mWpf             = 1;

    @(posedge clk);
    #1;
    checkOutput("rst_write_port", 64'({enaA, weA, addrA}), 64'd0);
    checkOutput("rst_diA", diA, 64'd0);
    checkOutput("rst_ptrs", 64'(ptrs), 64'd0);
    checkOutput("rst_ctrl", 64'({param_ready, act_in_ready, rd_release_ready, fill_done}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready_before_clock", 64'(rd_release_ready), 64'd0);
    tick(1);
    checkOutput("rel_ready_after_clock", 64'(rd_release_ready), 64'd1);
    checkOutput("param_ready_after_reset", 64'(param_ready), 64'd1);

    $display("[TB] scenario: 8 words, one fill");
    applyParams(8, 1);
    for (int i = 0; i < 8; i++) applyStimulus(64'hD100_0000_0000_0000 + 64'(i));
    checkOutput("t1_fill_done", 64'(fill_done), 64'd1);
    checkOutput("t1_ready_off", 64'(act_in_ready), 64'd0);
    checkOutput("t1_idle", 64'(param_ready), 64'd0);
    tick(1);
    checkOutput("t1_fill_done_once", 64'(fill_done), 64'd0);
    checkOutput("t1_param_read", 64'(param_ready), 64'd1);
    tick(1);
    checkOutput("t1_ptrs_new_half", 64'(ptrs), 64'({4{10'h200}}));

    $display("[TB] scenario: half 0 still held from previous fill");
    applyParams(4, 2);
    for (int i = 0; i < 4; i++) applyStimulus(64'hD1B0_0000_0000_0000 + 64'(i));
    checkOutput("t1b_half0_full", 64'(act_in_ready), 64'd0);
    doRelease(1'b0);
    tick(1);
    checkOutput("t1b_ready_after_release", 64'(act_in_ready), 64'd1);
    for (int i = 4; i < 8; i++) applyStimulus(64'hD1B0_0000_0000_0000 + 64'(i));
    checkOutput("t1b_fill_done", 64'(fill_done), 64'd1);
    doReset();

    $display("[TB] scenario: both halves full then release");
    applyParams(4, 3);
    for (int i = 0; i < 8; i++) applyStimulus(64'hD200_0000_0000_0000 + 64'(i));
    checkOutput("t2_ready_drops", 64'(act_in_ready), 64'd0);
    tick(3);
    checkOutput("t2_ready_stays_off", 64'(act_in_ready), 64'd0);
    doRelease(1'b0);
    tick(1);
    checkOutput("t2_ready_restored", 64'(act_in_ready), 64'd1);
    for (int i = 8; i < 12; i++) applyStimulus(64'hD200_0000_0000_0000 + 64'(i));
    checkOutput("t2_fill_done", 64'(fill_done), 64'd1);
    doReset();

    $display("[TB] scenario: 6 words, unequal bank counts");
    applyParams(6, 1);
    for (int i = 0; i < 5; i++) applyStimulus(64'hD300_0000_0000_0000 + 64'(i));
    tick(2);
    checkOutput("t3_ptrs_partial", 64'(ptrs), 64'({10'd1, 10'd1, 10'd1, 10'd2}));
    applyStimulus(64'hD300_0000_0000_0005);
    checkOutput("t3_fill_done", 64'(fill_done), 64'd1);
    tick(2);
    checkOutput("t3_ptrs_complete", 64'(ptrs), 64'({4{10'h200}}));
    doReset();

    $display("[TB] scenario: gapped input stream");
    applyParams(8, 1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(64'hD400_0000_0000_0000 + 64'(i));
      tick(1);
    end
    applyStimulus(64'hD400_0000_0000_0007);
    checkOutput("t4_fill_done", 64'(fill_done), 64'd1);
    doReset();

    $display("[TB] scenario: reset in the middle of a fill");
    applyParams(8, 1);
    for (int i = 0; i < 3; i++) applyStimulus(64'hD500_0000_0000_0000 + 64'(i));
    checkOutput("t5_enaA_before_reset", 64'(enaA), 64'h4);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_write_port", 64'({enaA, weA, addrA}), 64'd0);
    checkOutput("t5_async_diA", diA, 64'd0);
    checkOutput("t5_async_ptrs", 64'(ptrs), 64'd0);
    checkOutput("t5_async_ctrl", 64'({param_ready, act_in_ready, rd_release_ready, fill_done}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    checkOutput("t5_param_ready", 64'(param_ready), 64'd1);
    checkOutput("t5_act_ready", 64'(act_in_ready), 64'd0);
    checkOutput("t5_ptrs", 64'(ptrs), 64'd0);

    $display("[TB] scenario: fill of half 1 coincides with release of half 0");
    applyParams(4, 4);
    for (int i = 0; i < 7; i++) applyStimulus(64'hD600_0000_0000_0000 + 64'(i));
    act_in_data      = 64'hD600_0000_0000_0007;
    act_in_valid     = 1'b1;
    rd_release_valid = 1'b1;
    rd_release_data  = 1'b0;
    @(negedge clk);
    checkOutput("t6_beat_ready", 64'(act_in_ready), 64'd1);
    checkOutput("t6_release_ready", 64'(rd_release_ready), 64'd1);
    @(posedge clk);
    #1;
    act_in_valid     = 1'b0;
    rd_release_valid = 1'b0;
    checkOutput("t6_ready_next_cycle", 64'(act_in_ready), 64'd1);
    for (int i = 8; i < 12; i++) applyStimulus(64'hD600_0000_0000_0000 + 64'(i));
    checkOutput("t6_half1_kept_full", 64'(act_in_ready), 64'd0);
    doRelease(1'b1);
    tick(1);
    checkOutput("t6_ready_after_release1", 64'(act_in_ready), 64'd1);
    for (int i = 12; i < 16; i++) applyStimulus(64'hD600_0000_0000_0000 + 64'(i));
    checkOutput("t6_fill_done", 64'(fill_done), 64'd1);

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
